// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with 16x (OVERSAMPLE) oversampling.
//
// Receives an idle-high serial line (start bit low, 8 data bits LSB first,
// stop bit high). Each correctly framed byte is delivered on data_out with a
// one-cycle valid_out pulse. A low stop bit gives a one-cycle frame_err pulse.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, a parity bit is expected between the data and stop bits.
//   ODD_PARITY selects odd (1) or even (0) parity, and a one-cycle
//   parity_err pulse reports a mismatch at the end of the stop bit.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous active-high reset
//   serial_in  in   serial line, asynchronous to clk
//   data_out   out  last correctly framed byte, held until the next one
//   valid_out  out  one-cycle pulse, data_out updated this cycle
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   busy       out  high from start detect until return to IDLE
//   parity_err out  (UART_RX_PARITY_EN only) one-cycle parity mismatch pulse
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Expected parity bit for a data byte: XOR of the bits, inverted for odd.
    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

    state_t              state_r;
    logic                sync1_r;
    logic                sync2_r;
    logic                prev_r;
    logic [1:0]          settle_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [2:0]          bit_idx_r;
    logic [7:0]          shift_r;

    logic                tick_s;
    logic                fall_s;
    logic                start_s;
    logic                par_bad_s;

`ifdef UART_RX_PARITY_EN
    logic                parity_bit_r;
`endif

    // Derive the oversample tick, the synced falling edge and start detect.
    // The settle counter keeps the reset value of the sync flops (idle high)
    // from looking like a falling edge when the line is already low.
    always_comb begin
        tick_s  = (div_cnt_r == DIV_LAST);
        fall_s  = (settle_r == 2'd3) && prev_r && !sync2_r;
        start_s = (state_r == IDLE) && fall_s;
`ifdef UART_RX_PARITY_EN
        par_bad_s = (parity_bit_r != parity_of(shift_r, ODD_PARITY));
`else
        par_bad_s = 1'b0;
`endif
    end

    // Two-flop synchronizer, edge register and post-reset settle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            prev_r   <= 1'b1;
            settle_r <= 2'd0;
        end else begin
            sync1_r <= serial_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end
        end
    end

    // Baud divider: counts 0..DIV-1, realigned to the detected start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (start_s || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Receive FSM with registered outputs; tick counter advances on ticks only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            data_out   <= 8'h00;
            valid_out  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r    <= START;
                        busy       <= 1'b1;
                        tick_cnt_r <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (tick_cnt_r == TICK_MID) begin
                            tick_cnt_r <= '0;
                            if (!sync2_r) begin
                                bit_idx_r <= 3'd0;
                                state_r   <= DATA;
                            end else begin
                                // Start bit gone by its midpoint: a glitch.
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_r <= '0;
                            shift_r    <= {sync2_r, shift_r[7:1]};
                            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= PARITY;
`else
                                state_r <= STOP;
`endif
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_r   <= '0;
                            parity_bit_r <= sync2_r;
                            state_r      <= STOP;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_r <= '0;
                            state_r    <= IDLE;
                            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad_s;
`endif
                            if (!sync2_r) begin
                                frame_err <= 1'b1;
                            end else if (!par_bad_s) begin
                                data_out  <= shift_r;
                                valid_out <= 1'b1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    tick_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// CLK_FREQ=1_600_000, BAUD=10_000: DIV=10, 160 clk per bit.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    localparam int BIT_CLK = 160;

    int checks   = 0;
    int failures = 0;

    int         cyc             = 0;
    int         valid_cnt       = 0;
    int         frame_cnt       = 0;
    int         both_cnt        = 0;
    int         par_cnt         = 0;
    int         valid_cyc       = 0;
    int         prev_valid_cyc  = 0;
    logic [7:0] valid_data      = 8'h00;
    logic [7:0] prev_valid_data = 8'h00;
    logic       busy_at_valid   = 1'b1;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .serial_in(serial_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .frame_err(frame_err),
        .busy     (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            valid_cnt       <= valid_cnt + 1;
            prev_valid_cyc  <= valid_cyc;
            valid_cyc       <= cyc;
            prev_valid_data <= valid_data;
            valid_data      <= data_out;
            busy_at_valid   <= busy;
        end
        if (frame_err === 1'b1) frame_cnt <= frame_cnt + 1;
        if (valid_out === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) par_cnt <= par_cnt + 1;
`endif
    end

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Full frame; reports the start-edge cycle and whether busy stayed high.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic has_par, input logic par,
                              output int st, output logic bok);
        bok = 1'b1;
        st  = cyc;
        send_bit(1'b0);
        bok = bok & busy;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            bok = bok & busy;
        end
        if (has_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({data_out, valid_out, frame_err, busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_vals: got %h expected 000", {data_out, valid_out, frame_err, busy});
        end
        reset = 1'b0;
        repeat (2000) @(negedge clk);
        checks++;
        if (valid_cnt !== 0 || busy !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle: valid_cnt=%0d busy=%b data=%h expected 0 0 00", valid_cnt, busy, data_out);
        end
    endtask

    task automatic test_single;
        int   v0, st;
        logic bok;
        v0 = valid_cnt;
        send_frame(8'h49, 1'b1, 1'b0, 1'b0, st, bok);
        idle(200);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_data !== 8'h49) begin
            failures++;
            $display("FAIL single_data: pulses=%0d data=%h expected 1 49", valid_cnt - v0, valid_data);
        end
        checks++;
        if (valid_cyc - st < 1518 || valid_cyc - st > 1528) begin
            failures++;
            $display("FAIL single_latency: got %0d expected about 1523", valid_cyc - st);
        end
        checks++;
        if (bok !== 1'b1 || busy_at_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: in_frame=%b at_valid=%b expected 1 0", bok, busy_at_valid);
        end
    endtask

    task automatic test_back_to_back;
        int   v0, f0, st;
        logic bok;
        v0 = valid_cnt;
        f0 = frame_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, st, bok);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, st, bok);
        idle(200);
        checks++;
        if (valid_cnt !== v0 + 2 || prev_valid_data !== 8'hA5 || valid_data !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_data: pulses=%0d first=%h second=%h expected 2 a5 3c",
                     valid_cnt - v0, prev_valid_data, valid_data);
        end
        checks++;
        if (valid_cyc - prev_valid_cyc < 1595 || valid_cyc - prev_valid_cyc > 1605) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d expected 1600", valid_cyc - prev_valid_cyc);
        end
        checks++;
        if (frame_cnt !== f0) begin
            failures++;
            $display("FAIL b2b_frame_err: got %0d pulses expected 0", frame_cnt - f0);
        end
    endtask

    task automatic test_frame_err;
        int   v0, f0, st;
        logic bok;
        v0 = valid_cnt;
        f0 = frame_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, st, bok);
        checks++;
        if (frame_cnt !== f0 + 1 || valid_cnt !== v0 || data_out !== 8'h3C) begin
            failures++;
            $display("FAIL ferr_pulse: ferr=%0d valid=%0d data=%h expected 1 0 3c",
                     frame_cnt - f0, valid_cnt - v0, data_out);
        end
        repeat (3000) @(negedge clk);
        checks++;
        if (frame_cnt !== f0 + 1 || valid_cnt !== v0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_break: ferr=%0d valid=%0d busy=%b expected 1 0 0",
                     frame_cnt - f0, valid_cnt - v0, busy);
        end
        idle(320);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, st, bok);
        idle(200);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_data !== 8'h96) begin
            failures++;
            $display("FAIL ferr_recover: pulses=%0d data=%h expected 1 96", valid_cnt - v0, valid_data);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cnt;
        f0 = frame_cnt;
        serial_in = 1'b0;
        repeat (40) @(negedge clk);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start: busy=%b expected 1", busy);
        end
        repeat (200) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid_cnt !== v0 || frame_cnt !== f0) begin
            failures++;
            $display("FAIL glitch_abort: busy=%b valid=%0d ferr=%0d expected 0 0 0",
                     busy, valid_cnt - v0, frame_cnt - f0);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        v0 = valid_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_busy_now: busy=%b valid=%b expected 0 0", busy, valid_out);
        end
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2000);
        checks++;
        if (valid_cnt !== v0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL midrst_discard: valid=%0d data=%h expected 0 00", valid_cnt - v0, data_out);
        end
    endtask

    task automatic test_low_after_reset;
        int   v0, f0, st;
        logic bok;
        v0 = valid_cnt;
        f0 = frame_cnt;
        reset = 1'b1;
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (500) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_cnt !== f0 || valid_cnt !== v0) begin
            failures++;
            $display("FAIL lowrst_ignore: busy=%b ferr=%0d valid=%0d expected 0 0 0",
                     busy, frame_cnt - f0, valid_cnt - v0);
        end
        idle(320);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, st, bok);
        idle(200);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_data !== 8'h5A) begin
            failures++;
            $display("FAIL lowrst_frame: pulses=%0d data=%h expected 1 5a", valid_cnt - v0, valid_data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int   v0, p0, st;
        logic bok;
        v0 = valid_cnt;
        p0 = par_cnt;
        send_frame(8'h49, 1'b1, 1'b1, 1'b0, st, bok);
        idle(200);
        checks++;
        if (par_cnt !== p0 + 1 || valid_cnt !== v0 || data_out !== 8'h5A) begin
            failures++;
            $display("FAIL parity_bad: perr=%0d valid=%0d data=%h expected 1 0 5a",
                     par_cnt - p0, valid_cnt - v0, data_out);
        end
        send_frame(8'h49, 1'b1, 1'b1, 1'b1, st, bok);
        idle(200);
        checks++;
        if (par_cnt !== p0 + 1 || valid_cnt !== v0 + 1 || valid_data !== 8'h49) begin
            failures++;
            $display("FAIL parity_good: perr=%0d valid=%0d data=%h expected 0 1 49",
                     par_cnt - p0 - 1, valid_cnt - v0, valid_data);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_low_after_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL valid_and_ferr: got %0d coincident pulses expected 0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
